fifo_uart_tx: RTL and testbench
===============================

Name: fifo_uart_tx

Overview:
- Downstream consumer of the 8-bit FIFO buffer.
- Drains the FIFO one byte at a time and serializes each byte as an asynchronous UART frame on a single output line: start bit, LSB-first data, optional even parity, stop bit.
- Drives the FIFO read enable itself and never reads when the FIFO reports empty.

Parameters:
- DATA_W, 8, data width; matches the FIFO word width.
- CLKS_PER_BIT, 16, clk cycles per serial bit (must be >= 2).
- PARITY_EN, 0, 1 = append an even-parity bit after the data bits.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- tx_en  input  1  1 = allowed to start new frames.
- empty  input  1  FIFO empty flag.
- fifo_data  input  DATA_W  FIFO output_data; valid the cycle after REN is sampled high.
- REN  output  1  FIFO read enable, a single-cycle pulse.
- tx  output  1  serial line; idles high.
- busy  output  1  high from the READ state through the end of the stop bit.
- frame_done  output  1  one-cycle pulse on the last cycle of the stop bit.

Behaviour:
- Reset values (reset=0, asynchronous): tx=1, REN=0, busy=0, frame_done=0, state=IDLE, all counters 0, shift register 0.
- States: IDLE, READ, LOAD, START, DATA, PARITY, STOP.
- IDLE: if tx_en=1 and empty=0 -> READ; otherwise stay. tx=1, busy=0.
- READ: REN=1 for exactly this cycle -> LOAD. busy=1.
- LOAD: capture fifo_data into the shift register. Compute parity = XOR of the captured bits -> START.
- START: tx=0 for CLKS_PER_BIT cycles -> DATA.
- DATA: tx = shift_reg[0] for CLKS_PER_BIT cycles per bit, then shift right. After DATA_W bits: go to PARITY if PARITY_EN=1, else STOP.
- PARITY: tx = parity bit (even; total count of ones including the parity bit is even) for CLKS_PER_BIT cycles -> STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. frame_done=1 on the final cycle. Next state is READ if tx_en=1 and empty=0, else IDLE.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1 and clears on every state entry.
  - Bit transitions occur when it reaches CLKS_PER_BIT-1.
- Bit counter: width $clog2(DATA_W)+1, counts DATA bits only.
- Latency: tx falls (start bit) 3 clk cycles after the first IDLE cycle that sees empty=0 and tx_en=1 (IDLE->READ->LOAD->START registered).
- Back-to-back frames: exactly 2 extra tx-high cycles (READ, LOAD) between the stop bit and the next start bit.
- Frame length in cycles: (DATA_W+2+PARITY_EN)*CLKS_PER_BIT.
- Boundaries:
  - empty=1 in IDLE/STOP: never pulse REN. No reads past empty; no underflow possible.
  - tx_en deasserted mid-frame: the current frame completes normally, then the block returns to IDLE.
  - empty rising during a frame: no effect on the current byte (already captured in LOAD).
  - The captured byte is held in the shift register, so changes on fifo_data after LOAD are ignored.
  - Reset mid-frame: tx returns to 1 immediately and the in-flight byte is discarded. The FIFO is not re-read for it.
  - REN is never asserted in two consecutive cycles.

Decomposition:
- Shared package:
  - state enum (IDLE, READ, LOAD, START, DATA, PARITY, STOP)
  - constant FIFO_DATA_W=8
  - helper for the counter width, $clog2(CLKS_PER_BIT)
- One natural sub-module: uart_baud_tick. It holds the baud counter, has a clear input and a tick output, and is reusable by a future RX block.
- The FSM and shift register stay in the top module.

Test Plan:
- Bench parameters: CLKS_PER_BIT=4, PARITY_EN=0 unless noted. The bench uses the real FIFO as source.
- Reset then idle: reset=0 for 2 cycles, then 1, empty=1 -> tx=1, REN=0, busy=0 for 50 cycles. Assert reset mid-frame: tx=1 within the same cycle and the state returns to IDLE.
- Single byte: write 8'h01, tx_en=1 -> one REN pulse. tx sequence per 4-cycle bit is 0 (start),1,0,0,0,0,0,0,0,1 (stop). frame_done pulses once at cycle 40 of the frame.
- Burst of 8 bytes 8'h01, 8'h03 ... 8'hFF (FIFO full) -> 8 frames in order with 2-cycle gaps. Exactly 8 REN pulses. FIFO empty after the last READ. The block returns to IDLE with no extra REN.
- Parity: PARITY_EN=1, bytes 8'h07 then 8'hFF -> parity bits 1 then 0. Frame length 44 cycles.
- Flow control: tx_en dropped in the middle of the DATA bits of byte 8'hF0 with 8'hE0 still queued -> 8'hF0 finishes. No REN until tx_en returns to 1, then 8'hE0 is sent.
- Empty while busy: write 8'hAA. A second byte 8'h55 is written during the stop bit -> the STOP->READ transition is taken directly, with a 2-cycle gap.

Source files
------------

// File: rtl/fifo_uart_tx_pkg.sv
// rtl/fifo_uart_tx_pkg.sv - shared types and helpers for the FIFO-draining UART transmitter
package fifo_uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int FIFO_DATA_W = 8;

  function automatic int baud_cnt_w(input int clks_per_bit);
    return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - free-running bit-period counter with synchronous clear and end-of-bit tick
module uart_baud_tick
  import fifo_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                clear,
  output logic                                tick,
  output logic [baud_cnt_w(CLKS_PER_BIT)-1:0] count
);

  localparam int              CW   = baud_cnt_w(CLKS_PER_BIT);
  localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - drains a byte FIFO and serializes each byte as a UART frame
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int DATA_W       = FIFO_DATA_W,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_en,
  input  logic              empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              REN,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int            CW       = baud_cnt_w(CLKS_PER_BIT);
  localparam int            BW       = $clog2(DATA_W) + 1;
  localparam logic [CW-1:0] PRE_LAST = CW'(CLKS_PER_BIT - 2);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  state_t              state;
  logic [DATA_W-1:0]   shift_reg;
  logic                parity;
  logic [BW-1:0]       bit_cnt;
  logic                tick;
  logic                baud_clear;
  logic [CW-1:0]       baud_cnt;
  logic                can_start;

  // Holding the counter clear outside the timed states guarantees START begins at count 0.
  assign baud_clear = (state == IDLE) || (state == READ) || (state == LOAD);
  assign can_start  = tx_en && !empty;

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk   (clk),
    .reset (reset),
    .clear (baud_clear),
    .tick  (tick),
    .count (baud_cnt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      shift_reg  <= '0;
      parity     <= 1'b0;
      bit_cnt    <= '0;
      REN        <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      REN        <= 1'b0;
      frame_done <= (state == STOP) && (baud_cnt == PRE_LAST);
      case (state)
        IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          if (can_start) begin
            state <= READ;
            REN   <= 1'b1;
            busy  <= 1'b1;
          end
        end
        READ: state <= LOAD;
        LOAD: begin
          shift_reg <= fifo_data;
          parity    <= ^fifo_data;
          tx        <= 1'b0;
          state     <= START;
        end
        START: begin
          if (tick) begin
            tx      <= shift_reg[0];
            bit_cnt <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            shift_reg <= shift_reg >> 1;
            if (bit_cnt == LAST_BIT) begin
              state <= (PARITY_EN != 0) ? PARITY : STOP;
              tx    <= (PARITY_EN != 0) ? parity : 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx      <= shift_reg[1];
            end
          end
        end
        PARITY: begin
          if (tick) begin
            tx    <= 1'b1;
            state <= STOP;
          end
        end
        STOP: begin
          if (tick) begin
            if (can_start) begin
              state <= READ;
              REN   <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - scoreboard bench: two transmitters (no parity / even parity) fed by FIFO models
module tb_fifo_uart_tx;

  localparam int C = 4;

  typedef struct {
    logic [7:0] data;
    logic       par;
    int         gap;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] tx_en = 2'b00;
  logic [1:0] empty;
  logic [1:0] ren;
  logic [1:0] tx;
  logic [1:0] busy;
  logic [1:0] fdone;
  logic [7:0] fd [2];
  logic [1:0] wr_en = 2'b00;
  logic [7:0] wr_data [2];
  logic [7:0] mem [2][8];
  int         wp [2] = '{0, 0};
  int         rp [2] = '{0, 0};
  int         cnt [2] = '{0, 0};

  exp_t       exp_q [2][$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         ren_cnt [2] = '{0, 0};
  logic [1:0] prev_ren = 2'b00;
  int         last_fd [2] = '{0, 0};
  logic [1:0] mon_on = 2'b00;
  logic [1:0] mon_act = 2'b00;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fifo_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(C), .PARITY_EN(0)) dut0 (
    .clk(clk), .reset(reset), .tx_en(tx_en[0]), .empty(empty[0]), .fifo_data(fd[0]),
    .REN(ren[0]), .tx(tx[0]), .busy(busy[0]), .frame_done(fdone[0])
  );

  fifo_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(C), .PARITY_EN(1)) dut1 (
    .clk(clk), .reset(reset), .tx_en(tx_en[1]), .empty(empty[1]), .fifo_data(fd[1]),
    .REN(ren[1]), .tx(tx[1]), .busy(busy[1]), .frame_done(fdone[1])
  );

  // Depth-8 source FIFOs; read data appears the cycle after REN is sampled.
  always_comb begin
    empty = 2'b00;
    for (int g = 0; g < 2; g++) empty[g] = (cnt[g] == 0);
  end

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (wr_en[g] && cnt[g] < 8) begin
        mem[g][wp[g]] <= wr_data[g];
        wp[g] <= (wp[g] + 1) % 8;
      end
      if (ren[g] && cnt[g] > 0) begin
        fd[g] <= mem[g][rp[g]];
        rp[g] <= (rp[g] + 1) % 8;
      end
      cnt[g] <= cnt[g] + ((wr_en[g] && cnt[g] < 8) ? 1 : 0) - ((ren[g] && cnt[g] > 0) ? 1 : 0);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wr(input int ch, input logic [7:0] d);
    @(negedge clk);
    wr_en[ch] = 1'b1;
    wr_data[ch] = d;
    @(negedge clk);
    wr_en[ch] = 1'b0;
  endtask

  task automatic push(input int ch, input logic [7:0] d, input logic p, input int gap);
    exp_t e;
    e.data = d;
    e.par = p;
    e.gap = gap;
    exp_q[ch].push_back(e);
    wr(ch, d);
  endtask

  task automatic wait_fall(input int ch, output int n);
    n = 0;
    while (tx[ch] && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("tx_fall_timeout", int'(n < 400), 1);
  endtask

  task automatic drain(input int ch, input int budget);
    int n = 0;
    while ((exp_q[ch].size() != 0 || mon_act[ch] || busy[ch]) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", int'(n < budget), 1);
  endtask

  // Monitor: decodes each frame on the line at mid-bit and compares with the scoreboard.
  task automatic mon(input int ch);
    exp_t       e;
    logic [7:0] b;
    int         s;
    forever begin
      @(negedge clk);
      if (mon_on[ch] && reset && tx[ch] == 1'b0) begin
        mon_act[ch] = 1'b1;
        s = cyc;
        if (exp_q[ch].size() == 0) begin
          check("unexpected_frame", 0, 1);
          e.data = 8'h00;
          e.par = 1'b0;
          e.gap = -1;
        end else begin
          e = exp_q[ch].pop_front();
        end
        if (e.gap >= 0) check("gap", s - last_fd[ch] - 1, e.gap);
        repeat (C / 2) @(negedge clk);
        check("start_bit", int'(tx[ch]), 0);
        for (int i = 0; i < 8; i++) begin
          repeat (C) @(negedge clk);
          b[i] = tx[ch];
        end
        check("data", int'(b), int'(e.data));
        if (ch == 1) begin
          repeat (C) @(negedge clk);
          check("parity", int'(tx[ch]), int'(e.par));
        end
        repeat (C) @(negedge clk);
        check("stop_bit", int'(tx[ch]), 1);
        check("frame_done_early", int'(fdone[ch]), 0);
        repeat (C / 2 - 1) @(negedge clk);
        check("frame_done", int'(fdone[ch]), 1);
        last_fd[ch] = cyc;
        mon_act[ch] = 1'b0;
      end
    end
  endtask

  initial mon(0);
  initial mon(1);

  initial begin
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (ren[g]) begin
          ren_cnt[g]++;
          check("ren_when_empty", int'(empty[g]), 0);
          check("ren_back_to_back", int'(prev_ren[g]), 0);
        end
      end
      prev_ren = ren;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   r0;
    logic bad;
    logic [7:0] d;

    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_tx", int'(tx), 3);
    check("reset_ren_busy_fdone", int'({ren, busy, fdone}), 0);
    reset = 1'b1;
    bad = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (tx != 2'b11 || ren != 2'b00 || busy != 2'b00) bad = 1'b1;
    end
    check("idle_50", int'(bad), 0);
    mon_on = 2'b11;

    // single byte plus start latency
    tx_en[0] = 1'b1;
    r0 = ren_cnt[0];
    push(0, 8'h01, 1'b0, -1);
    n = 0;
    while (tx[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("start_latency", n, 3);
    drain(0, 200);
    check("single_ren_count", ren_cnt[0] - r0, 1);

    // burst of eight with FIFO full before enabling
    tx_en[0] = 1'b0;
    r0 = ren_cnt[0];
    d = 8'h01;
    for (int i = 0; i < 8; i++) begin
      push(0, d, 1'b0, (i == 0) ? -1 : 2);
      d = {d[6:0], 1'b1};
    end
    tx_en[0] = 1'b1;
    drain(0, 8 * 60 + 100);
    check("burst_ren_count", ren_cnt[0] - r0, 8);
    check("burst_fifo_empty", int'(empty[0]), 1);
    repeat (30) @(negedge clk);
    check("burst_no_extra_ren", ren_cnt[0] - r0, 8);
    check("burst_idle_busy", int'(busy[0]), 0);

    // flow control: drop tx_en during F0 data bits with E0 queued
    r0 = ren_cnt[0];
    push(0, 8'hF0, 1'b0, -1);
    push(0, 8'hE0, 1'b0, -1);
    wait_fall(0, n);
    repeat (5 * C) @(negedge clk);
    tx_en[0] = 1'b0;
    n = 0;
    while ((mon_act[0] || busy[0]) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("flow_f0_done", int'(n < 200), 1);
    check("flow_one_read", ren_cnt[0] - r0, 1);
    repeat (40) @(negedge clk);
    check("flow_no_read_disabled", ren_cnt[0] - r0, 1);
    check("flow_idle_tx", int'(tx[0]), 1);
    tx_en[0] = 1'b1;
    drain(0, 200);
    check("flow_two_reads", ren_cnt[0] - r0, 2);

    // second byte arrives during the stop bit
    r0 = ren_cnt[0];
    push(0, 8'hAA, 1'b0, -1);
    wait_fall(0, n);
    repeat (9 * C) @(negedge clk);
    push(0, 8'h55, 1'b0, 2);
    drain(0, 200);
    check("stop_refill_reads", ren_cnt[0] - r0, 2);

    // reset mid-frame
    mon_on[0] = 1'b0;
    r0 = ren_cnt[0];
    wr(0, 8'h5A);
    wait_fall(0, n);
    repeat (3 * C) @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_mid_tx", int'(tx[0]), 1);
    check("reset_mid_busy", int'(busy[0]), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (tx[0] != 1'b1 || busy[0] != 1'b0) bad = 1'b1;
    end
    check("reset_mid_stays_idle", int'(bad), 0);
    check("reset_mid_no_reread", ren_cnt[0] - r0, 1);
    mon_on[0] = 1'b1;

    // even parity, 44-cycle frames
    tx_en[1] = 1'b1;
    r0 = ren_cnt[1];
    push(1, 8'h07, 1'b1, -1);
    push(1, 8'hFF, 1'b0, 2);
    drain(1, 300);
    check("parity_ren_count", ren_cnt[1] - r0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
